// File: rtl/memory_port_arbiter.sv
// ============================================================================
// Module   : memory_port_arbiter
// Brief    : Core / DMA arbiter for the backend data port, with bounded DMA wait
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        coreReq,
  input  logic        coreWrite,
  input  logic [29:0] coreAddress,
  input  logic [31:0] coreDataIn,
  output logic        coreAck,
  output logic [31:0] coreDataOut,
  input  logic        dmaReq,
  input  logic        dmaWrite,
  input  logic [29:0] dmaAddress,
  input  logic [31:0] dmaDataIn,
  output logic        dmaAck,
  output logic [31:0] dmaDataOut,
  output logic [29:0] backendAddress,
  output logic [31:0] backendDataIn,
  output logic        backendWriteEnable,
  input  logic [31:0] backendDataOut,
  output logic        arbiterBusy
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner_dma;
  logic        r_write;
  logic        r_we;
  logic        r_core_ack;
  logic        r_dma_ack;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_core_data;
  logic [31:0] r_dma_data;
  logic [3:0]  r_starve_count;

  logic        w_grant_dma;

  // Core wins ties until it has starved a waiting DMA for STARVE_LIMIT grants.
  assign w_grant_dma = dmaReq && (!coreReq || (r_starve_count >= c_starve_limit));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_owner_dma    <= 1'b0;
      r_write        <= 1'b0;
      r_we           <= 1'b0;
      r_core_ack     <= 1'b0;
      r_dma_ack      <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_core_data    <= '0;
      r_dma_data     <= '0;
      r_starve_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (coreReq || dmaReq) begin
            r_state     <= ISSUE;
            r_owner_dma <= w_grant_dma;
            r_write     <= w_grant_dma ? dmaWrite    : coreWrite;
            r_we        <= w_grant_dma ? dmaWrite    : coreWrite;
            r_addr      <= w_grant_dma ? dmaAddress  : coreAddress;
            r_wdata     <= w_grant_dma ? dmaDataIn   : coreDataIn;
            if (w_grant_dma || !dmaReq)
              r_starve_count <= '0;
            else if (r_starve_count != 4'hF)
              r_starve_count <= r_starve_count + 4'd1;
          end
        end
        ISSUE: begin
          r_state    <= CAPTURE;
          r_we       <= 1'b0;
          r_core_ack <= !r_owner_dma;
          r_dma_ack  <= r_owner_dma;
        end
        CAPTURE: begin
          r_state    <= IDLE;
          r_core_ack <= 1'b0;
          r_dma_ack  <= 1'b0;
          if (!r_write) begin
            if (r_owner_dma)
              r_dma_data <= backendDataOut;
            else
              r_core_data <= backendDataOut;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign backendAddress     = r_addr;
  assign backendDataIn      = r_wdata;
  assign backendWriteEnable = r_we;
  assign arbiterBusy        = (r_state != IDLE);
  assign coreAck            = r_core_ack;
  assign dmaAck             = r_dma_ack;

  // Read data is forwarded live during CAPTURE, then held from the register.
  assign coreDataOut = (r_core_ack && !r_write) ? backendDataOut : r_core_data;
  assign dmaDataOut  = (r_dma_ack  && !r_write) ? backendDataOut : r_dma_data;

endmodule

`default_nettype wire

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Two-requester arbiter sharing the single data read/write port of the memory backend (RAM plus MMIO window) between the core load/store path and a DMA/debug master. Sits directly in front of the backend's data port; the instruction fetch port is untouched. Each granted access is latched, issued for one cycle, completed with an ack pulse, with a starvation counter bounding DMA wait under sustained core traffic. Address decode (RAM vs. MMIO via address bit 29) stays in the backend; this block passes addresses through unchanged.

## Interface
- STARVE_LIMIT, default 4: max consecutive core grants while DMA is requesting before DMA is forced through; legal range 1..15.
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- coreReq  in  1  core access request; held high until coreAck
- coreWrite  in  1  1 = write, 0 = read
- coreAddress  in  30  word address
- coreDataIn  in  32  write data
- coreAck  out  1  one-cycle completion pulse
- coreDataOut  out  32  read data
- dmaReq, dmaWrite, dmaAddress (30), dmaDataIn (32), dmaAck, dmaDataOut (32): same semantics for the DMA requester
- backendAddress  out  30  to backend
- backendDataIn  out  32  to backend
- backendWriteEnable  out  1  to backend
- backendDataOut  in  32  from backend; valid one cycle after address presented
- arbiterBusy  out  1  high when state != IDLE

## Operation
- FSM states: IDLE, ISSUE, CAPTURE. IDLE -> ISSUE when any req high at the edge; ISSUE -> CAPTURE unconditionally; CAPTURE -> IDLE unconditionally.
- Grant decision at the edge leaving IDLE: single requester wins; both high -> core, unless starveCount >= STARVE_LIMIT, then DMA.
- On grant: latch owner, write flag, address, write data into internal registers; requester inputs other than req are don't-care afterwards.
- starveCount (4 bits) updated only on grant: DMA granted -> 0; core granted with dmaReq high -> saturating +1; core granted with dmaReq low -> 0.
- ISSUE: backendAddress/backendDataIn = latched values; backendWriteEnable = latched write flag.
- CAPTURE: backendWriteEnable = 0; backendAddress still latched value; owner's ack = 1; for reads owner's dataOut = backendDataOut combinationally, and the value is registered at end of CAPTURE.
- Outside CAPTURE, coreDataOut/dmaDataOut hold last captured read value; writes never change them.
- Non-owner ack always 0. backendAddress/backendDataIn hold last latched values in IDLE.
- Requester deasserts req the cycle after its ack; a req sampled high in IDLE is a new access. Req dropped before grant = withdrawn, never serviced.
- Reset (async): state IDLE, backendWriteEnable 0 immediately, both acks 0, starveCount 0, backendAddress 0, backendDataIn 0, both dataOut 0. In-flight access is abandoned without ack; a write in ISSUE is suppressed if reset asserts before the edge ending ISSUE.

## Timing
- Req sampled high at edge E0 -> ISSUE in cycle 1 -> CAPTURE/ack in cycle 2 -> IDLE in cycle 3.
- Ack latency 2 cycles after the sampling edge; throughput 1 access per 3 cycles.
- Write commits at the edge ending ISSUE; read data valid throughout CAPTURE.
- Loser of simultaneous arbitration keeps req high; earliest grant is the edge ending the IDLE cycle that follows the winner's CAPTURE.
- No combinational path from any req input to backend outputs.

## Test plan
- Single core read of 0x00000010 (RAM holds 0xDEADBEEF) -> ISSUE one cycle after req edge, coreAck pulse 2 cycles after, coreDataOut = 0xDEADBEEF and holds; dmaAck stays 0.
- DMA write 0x12345678 to 0x3FFFFFF8 (MMIO) -> backendWriteEnable high exactly one cycle, mmio output 0 reads 0x12345678; dmaDataOut unchanged.
- Both requesting continuously, STARVE_LIMIT=4 -> grant sequence core,core,core,core,DMA repeating; starveCount returns to 0 after each DMA grant.
- Simultaneous req with dmaReq dropped before its grant -> DMA never acked, starveCount resets to 0 on next core grant.
- Reset asserted mid-ISSUE of a core write to 0x00000020 -> backendWriteEnable falls asynchronously, location keeps old value, no coreAck, all outputs at reset values.
- Back-to-back core reads to 0x0 and 0x1 -> acks exactly 3 cycles apart, each coreDataOut matches its RAM word.
